seletor_aprovados: RTL and testbench
====================================

Name: seletor_aprovados

Overview:
- Sits directly downstream of the active-node evaluator (avaliador_ativos).
- Once classification is ready, captures a snapshot of the approved active nodes. Serialises them one per handshake to the valid-neighbour locator (lvv) and writes each node's predecessor into the predecessor memory.
- After the last approved node, pulses the classification-update strobe that re-arms the evaluator.

Parameters:
- NUM_NA, 4, number of active-node slots
- ADDR_WIDTH, 5, node address width
- DISTANCIA_WIDTH, 5, distance width
- IDX_WIDTH, $clog2(NUM_NA) (min 1), slot index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- aa_pronto_in  in  1  evaluator classification complete (level)
- aa_aprovado_in  in  NUM_NA  approved flag per slot
- aa_endereco_in  in  ADDR_WIDTH*NUM_NA  node address per slot, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
- aa_distancia_in  in  DISTANCIA_WIDTH*NUM_NA  distance per slot, same packing
- aa_anterior_data_in  in  ADDR_WIDTH*NUM_NA  predecessor per slot, same packing
- lvv_ready_in  in  1  locator accepts a node this cycle
- sa_valido_out  out  1  node offered to locator
- sa_endereco_out  out  ADDR_WIDTH  offered node address
- sa_distancia_out  out  DISTANCIA_WIDTH  offered node distance
- sa_indice_out  out  IDX_WIDTH  slot index of offered node
- sa_anterior_wr_en_out  out  1  predecessor-memory write enable
- sa_anterior_addr_out  out  ADDR_WIDTH  write address (node address)
- sa_anterior_data_out  out  ADDR_WIDTH  write data (predecessor)
- sa_atualizar_classificacao_out  out  1  one-cycle pulse; drives the evaluator's cme_atualizar_classificacao_in
- sa_sem_aprovado_out  out  1  one-cycle pulse: snapshot held no approved node
- sa_ocupado_out  out  1  state != OCIOSO

Behaviour:
- Reset: rst_n is sampled on the clk edge only (no async path). Reset forces state OCIOSO and clears the pending mask and snapshot registers. All outputs are 0 at reset.
- States: OCIOSO, EMITE, FIM, ESPERA.
- OCIOSO:
  - If aa_pronto_in=1, register aa_aprovado_in into pending mask P, and all three data buses into snapshot regs (one-cycle capture).
  - If aa_aprovado_in==0, pulse sa_sem_aprovado_out next cycle, pulse sa_atualizar_classificacao_out in that same cycle, and go to ESPERA.
  - Otherwise go to EMITE.
- EMITE:
  - Selected slot k = lowest set bit of P (fixed priority, index 0 highest).
  - sa_valido_out=1; endereco, distancia and indice come combinationally from the snapshot at k.
  - Outputs stay stable while lvv_ready_in=0.
  - On sa_valido_out && lvv_ready_in, in the same cycle:
    - sa_anterior_wr_en_out=1, addr = snapshot endereco[k], data = snapshot anterior[k].
    - Clear P[k].
    - If P with k cleared is 0, go to FIM.
  - sa_anterior_wr_en_out is never asserted without an accepted handshake.
- FIM: sa_atualizar_classificacao_out=1 for exactly one cycle; go to ESPERA.
- ESPERA: stay one cycle so the registered aa_pronto_in falls, then go to OCIOSO. Prevents re-capturing a stale ready.
- Snapshot isolation: changes on the aa_* inputs during EMITE/FIM/ESPERA are ignored.
- Throughput: one node per cycle when lvv_ready_in is held 1. Latency from aa_pronto_in sample to first sa_valido_out is 1 cycle.
- Reset mid-EMITE: the pending node is dropped, no write occurs, and no update pulse is emitted.
- All-slots approved (P all ones): exactly NUM_NA handshakes, in index order 0..NUM_NA-1.

Decomposition:
- Shared package: state encoding localparams (OCIOSO=0, EMITE=1, FIM=2, ESPERA=3) and the slot-index width function.
- One natural sub-module: codificador_prioridade. It is a parametric lowest-set-bit encoder: NUM_NA-bit mask in; IDX_WIDTH index and "any" flag out.
- The rest (FSM, snapshot, mux) stays in seletor_aprovados.

Test Plan:
- Reset, then aa_pronto_in=1, aprovado=4'b0101, ready=1 -> two handshakes, at slots 0 then 2.
  - Two writes (addr/data from slots 0, 2), then one sa_atualizar_classificacao_out pulse.
  - Then ESPERA, and OCIOSO with sa_ocupado_out=0.
- aprovado=4'b0000 with aa_pronto_in=1 -> sa_sem_aprovado_out and sa_atualizar_classificacao_out pulse together, one cycle.
  - No sa_valido_out, no write.
- aprovado=4'b1000, lvv_ready_in held 0 for 5 cycles then 1 -> sa_valido_out held 6 cycles with stable addr/index=3.
  - Single write on the 6th cycle.
- aprovado=4'b1111, ready=1 continuously -> 4 consecutive write cycles, indices 0,1,2,3.
  - Update pulse on the cycle after the last write.
- During EMITE, change aa_endereco_in/aa_aprovado_in -> emitted addresses equal the captured snapshot values.
- Assert rst_n=0 for one clk edge during EMITE with 2 nodes pending -> next cycle all outputs 0, state OCIOSO.
  - No update pulse follows.

Source files
------------

// File: rtl/seletor_aprovados_pkg.sv
// Shared types and helpers for the approved-node selector.
package seletor_aprovados_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EMITE  = 2'd1,
    FIM    = 2'd2,
    ESPERA = 2'd3
  } estado_t;

  // Slot-index width; a single slot still needs one index bit.
  function automatic int idx_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seletor_aprovados_codificador_prioridade.sv
// Lowest-set-bit encoder: slot 0 has the highest priority.
module codificador_prioridade
  import seletor_aprovados_pkg::*;
#(
  parameter int NUM_NA    = 4,
  parameter int IDX_WIDTH = idx_width(NUM_NA)
) (
  input  logic [NUM_NA-1:0]    mascara_in,
  output logic [IDX_WIDTH-1:0] indice_out,
  output logic                 algum_out
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    indice_out = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (mascara_in[i]) indice_out = IDX_WIDTH'(i);
    end
  end

  assign algum_out = |mascara_in;

endmodule

// File: rtl/seletor_aprovados.sv
// Snapshots the evaluator's approved nodes and serialises them to the
// valid-neighbour locator, writing each node's predecessor on acceptance.
//
// state  | meaning
// OCIOSO | idle, waiting for aa_pronto_in to capture a snapshot
// EMITE  | offering the lowest pending slot to the locator
// FIM    | all nodes sent; one-cycle classification-update pulse
// ESPERA | one guard cycle so the evaluator's ready can fall
module seletor_aprovados
  import seletor_aprovados_pkg::*;
#(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int IDX_WIDTH       = idx_width(NUM_NA)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              aa_pronto_in,
  input  logic [NUM_NA-1:0]                 aa_aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_in,
  input  logic                              lvv_ready_in,
  output logic                              sa_valido_out,
  output logic [ADDR_WIDTH-1:0]             sa_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]        sa_distancia_out,
  output logic [IDX_WIDTH-1:0]              sa_indice_out,
  output logic                              sa_anterior_wr_en_out,
  output logic [ADDR_WIDTH-1:0]             sa_anterior_addr_out,
  output logic [ADDR_WIDTH-1:0]             sa_anterior_data_out,
  output logic                              sa_atualizar_classificacao_out,
  output logic                              sa_sem_aprovado_out,
  output logic                              sa_ocupado_out
);

  estado_t                    estado_q, estado_d;
  logic [NUM_NA-1:0]          pend_q, pend_d;
  logic                       sem_q, sem_d;
  logic [ADDR_WIDTH-1:0]      end_q  [NUM_NA];
  logic [ADDR_WIDTH-1:0]      end_d  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] dist_q [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] dist_d [NUM_NA];
  logic [ADDR_WIDTH-1:0]      ant_q  [NUM_NA];
  logic [ADDR_WIDTH-1:0]      ant_d  [NUM_NA];

  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 sel_algum;
  logic [NUM_NA-1:0]    sel_bit;
  logic                 aceito;

  codificador_prioridade #(
    .NUM_NA    (NUM_NA),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_prio (
    .mascara_in (pend_q),
    .indice_out (sel_idx),
    .algum_out  (sel_algum)
  );

  // Next-state, snapshot capture and output mux.
  always_comb begin
    estado_d = estado_q;
    pend_d   = pend_q;
    sem_d    = 1'b0;
    end_d    = end_q;
    dist_d   = dist_q;
    ant_d    = ant_q;
    sel_bit  = '0;
    aceito   = 1'b0;

    sa_valido_out                  = 1'b0;
    sa_endereco_out                = '0;
    sa_distancia_out               = '0;
    sa_indice_out                  = '0;
    sa_anterior_wr_en_out          = 1'b0;
    sa_anterior_addr_out           = '0;
    sa_anterior_data_out           = '0;
    sa_atualizar_classificacao_out = 1'b0;
    sa_sem_aprovado_out            = 1'b0;
    sa_ocupado_out                 = (estado_q != OCIOSO);

    unique case (estado_q)
      OCIOSO: begin
        if (aa_pronto_in) begin
          pend_d = aa_aprovado_in;
          for (int i = 0; i < NUM_NA; i++) begin
            end_d[i]  = aa_endereco_in[ADDR_WIDTH*i +: ADDR_WIDTH];
            dist_d[i] = aa_distancia_in[DISTANCIA_WIDTH*i +: DISTANCIA_WIDTH];
            ant_d[i]  = aa_anterior_data_in[ADDR_WIDTH*i +: ADDR_WIDTH];
          end
          if (aa_aprovado_in == '0) begin
            sem_d    = 1'b1;
            estado_d = ESPERA;
          end else begin
            estado_d = EMITE;
          end
        end
      end
      EMITE: begin
        if (sel_algum) begin
          sa_valido_out    = 1'b1;
          sa_endereco_out  = end_q[sel_idx];
          sa_distancia_out = dist_q[sel_idx];
          sa_indice_out    = sel_idx;
          aceito           = lvv_ready_in;
        end else begin
          // Unreachable with a sane mask; recover instead of stalling.
          estado_d = FIM;
        end
        if (aceito) begin
          sa_anterior_wr_en_out = 1'b1;
          sa_anterior_addr_out  = end_q[sel_idx];
          sa_anterior_data_out  = ant_q[sel_idx];
          sel_bit[sel_idx]      = 1'b1;
          pend_d                = pend_q & ~sel_bit;
          if (pend_d == '0) estado_d = FIM;
        end
      end
      FIM: begin
        sa_atualizar_classificacao_out = 1'b1;
        estado_d                       = ESPERA;
      end
      ESPERA: begin
        // An empty snapshot reports both pulses here, one cycle after capture.
        sa_sem_aprovado_out            = sem_q;
        sa_atualizar_classificacao_out = sem_q;
        estado_d                       = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State, pending mask and snapshot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      pend_q   <= '0;
      sem_q    <= 1'b0;
      for (int i = 0; i < NUM_NA; i++) begin
        end_q[i]  <= '0;
        dist_q[i] <= '0;
        ant_q[i]  <= '0;
      end
    end else begin
      estado_q <= estado_d;
      pend_q   <= pend_d;
      sem_q    <= sem_d;
      end_q    <= end_d;
      dist_q   <= dist_d;
      ant_q    <= ant_d;
    end
  end

endmodule

// File: tb/tb_seletor_aprovados.sv
// Directed bench for seletor_aprovados. Inputs change on the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_seletor_aprovados;

  localparam int NUM_NA = 4;
  localparam int AW     = 5;
  localparam int DW     = 5;
  localparam int IW     = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              aa_pronto_in;
  logic [NUM_NA-1:0] aa_aprovado_in;
  logic [AW*NUM_NA-1:0] aa_endereco_in;
  logic [DW*NUM_NA-1:0] aa_distancia_in;
  logic [AW*NUM_NA-1:0] aa_anterior_data_in;
  logic              lvv_ready_in;
  logic              sa_valido_out;
  logic [AW-1:0]     sa_endereco_out;
  logic [DW-1:0]     sa_distancia_out;
  logic [IW-1:0]     sa_indice_out;
  logic              sa_anterior_wr_en_out;
  logic [AW-1:0]     sa_anterior_addr_out;
  logic [AW-1:0]     sa_anterior_data_out;
  logic              sa_atualizar_classificacao_out;
  logic              sa_sem_aprovado_out;
  logic              sa_ocupado_out;

  int checks   = 0;
  int failures = 0;

  // Slot i carries address 10+i, distance 20+i, predecessor 1+i.
  localparam logic [AW*NUM_NA-1:0] END_BASE = {5'd13, 5'd12, 5'd11, 5'd10};
  localparam logic [DW*NUM_NA-1:0] DIS_BASE = {5'd23, 5'd22, 5'd21, 5'd20};
  localparam logic [AW*NUM_NA-1:0] ANT_BASE = {5'd4, 5'd3, 5'd2, 5'd1};

  always #5 clk = ~clk;

  seletor_aprovados dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .aa_pronto_in                   (aa_pronto_in),
    .aa_aprovado_in                 (aa_aprovado_in),
    .aa_endereco_in                 (aa_endereco_in),
    .aa_distancia_in                (aa_distancia_in),
    .aa_anterior_data_in            (aa_anterior_data_in),
    .lvv_ready_in                   (lvv_ready_in),
    .sa_valido_out                  (sa_valido_out),
    .sa_endereco_out                (sa_endereco_out),
    .sa_distancia_out               (sa_distancia_out),
    .sa_indice_out                  (sa_indice_out),
    .sa_anterior_wr_en_out          (sa_anterior_wr_en_out),
    .sa_anterior_addr_out           (sa_anterior_addr_out),
    .sa_anterior_data_out           (sa_anterior_data_out),
    .sa_atualizar_classificacao_out (sa_atualizar_classificacao_out),
    .sa_sem_aprovado_out            (sa_sem_aprovado_out),
    .sa_ocupado_out                 (sa_ocupado_out)
  );

  task automatic start_snapshot(input logic [NUM_NA-1:0] aprov, input logic rdy);
    @(negedge clk);
    aa_pronto_in   = 1'b1;
    aa_aprovado_in = aprov;
    lvv_ready_in   = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    aa_pronto_in = 1'b1;
    aa_aprovado_in = 4'b1111;
    aa_endereco_in = END_BASE;
    aa_distancia_in = DIS_BASE;
    aa_anterior_data_in = ANT_BASE;
    lvv_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({sa_valido_out, sa_anterior_wr_en_out, sa_atualizar_classificacao_out,
         sa_sem_aprovado_out, sa_ocupado_out} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {sa_valido_out, sa_anterior_wr_en_out,
               sa_atualizar_classificacao_out, sa_sem_aprovado_out, sa_ocupado_out});
    end
    checks++;
    if ({sa_endereco_out, sa_distancia_out, sa_indice_out, sa_anterior_addr_out,
         sa_anterior_data_out} !== '0) begin
      failures++;
      $display("FAIL reset_data got addr=%0d dist=%0d idx=%0d", sa_endereco_out,
               sa_distancia_out, sa_indice_out);
    end
    @(negedge clk);
    aa_pronto_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_nodes();
    int exp_k[2] = '{0, 2};
    start_snapshot(4'b0101, 1'b1);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      aa_pronto_in = 1'b0;
      #1;
      checks++;
      if (!(sa_valido_out === 1'b1 && sa_indice_out === IW'(exp_k[n]) &&
            sa_endereco_out === AW'(10 + exp_k[n]) && sa_distancia_out === DW'(20 + exp_k[n]))) begin
        failures++;
        $display("FAIL two_offer%0d got v=%b idx=%0d addr=%0d dist=%0d want idx=%0d", n,
                 sa_valido_out, sa_indice_out, sa_endereco_out, sa_distancia_out, exp_k[n]);
      end
      checks++;
      if (!(sa_anterior_wr_en_out === 1'b1 && sa_anterior_addr_out === AW'(10 + exp_k[n]) &&
            sa_anterior_data_out === AW'(1 + exp_k[n]) && sa_atualizar_classificacao_out === 1'b0)) begin
        failures++;
        $display("FAIL two_write%0d got we=%b addr=%0d data=%0d upd=%b want addr=%0d data=%0d",
                 n, sa_anterior_wr_en_out, sa_anterior_addr_out, sa_anterior_data_out,
                 sa_atualizar_classificacao_out, 10 + exp_k[n], 1 + exp_k[n]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_atualizar_classificacao_out === 1'b1 && sa_valido_out === 1'b0 &&
          sa_anterior_wr_en_out === 1'b0 && sa_ocupado_out === 1'b1)) begin
      failures++;
      $display("FAIL two_fim got upd=%b v=%b we=%b busy=%b want 1 0 0 1",
               sa_atualizar_classificacao_out, sa_valido_out, sa_anterior_wr_en_out, sa_ocupado_out);
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_atualizar_classificacao_out === 1'b0 && sa_ocupado_out === 1'b1)) begin
      failures++;
      $display("FAIL two_espera got upd=%b busy=%b want 0 1",
               sa_atualizar_classificacao_out, sa_ocupado_out);
    end
    @(negedge clk); #1;
    checks++;
    if (sa_ocupado_out !== 1'b0) begin
      failures++;
      $display("FAIL two_idle got busy=%b want 0", sa_ocupado_out);
    end
  endtask

  task automatic test_none_approved();
    start_snapshot(4'b0000, 1'b1);
    @(negedge clk);
    aa_pronto_in = 1'b0;
    #1;
    checks++;
    if (!(sa_sem_aprovado_out === 1'b1 && sa_atualizar_classificacao_out === 1'b1 &&
          sa_valido_out === 1'b0 && sa_anterior_wr_en_out === 1'b0)) begin
      failures++;
      $display("FAIL none_pulse got sem=%b upd=%b v=%b we=%b want 1 1 0 0", sa_sem_aprovado_out,
               sa_atualizar_classificacao_out, sa_valido_out, sa_anterior_wr_en_out);
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_sem_aprovado_out === 1'b0 && sa_atualizar_classificacao_out === 1'b0 &&
          sa_ocupado_out === 1'b0)) begin
      failures++;
      $display("FAIL none_after got sem=%b upd=%b busy=%b want 0 0 0", sa_sem_aprovado_out,
               sa_atualizar_classificacao_out, sa_ocupado_out);
    end
  endtask

  task automatic test_backpressure();
    start_snapshot(4'b1000, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      aa_pronto_in = 1'b0;
      lvv_ready_in = (c == 5);
      #1;
      checks++;
      if (!(sa_valido_out === 1'b1 && sa_indice_out === 2'd3 && sa_endereco_out === 5'd13 &&
            sa_anterior_wr_en_out === (c == 5))) begin
        failures++;
        $display("FAIL bp_cycle%0d got v=%b idx=%0d addr=%0d we=%b want 1 3 13 %b", c,
                 sa_valido_out, sa_indice_out, sa_endereco_out, sa_anterior_wr_en_out, c == 5);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_atualizar_classificacao_out === 1'b1 && sa_valido_out === 1'b0)) begin
      failures++;
      $display("FAIL bp_fim got upd=%b v=%b want 1 0", sa_atualizar_classificacao_out, sa_valido_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start_snapshot(4'b1111, 1'b1);
    for (int i = 0; i < NUM_NA; i++) begin
      @(negedge clk);
      aa_pronto_in = 1'b0;
      #1;
      checks++;
      if (!(sa_anterior_wr_en_out === 1'b1 && sa_indice_out === IW'(i) &&
            sa_anterior_addr_out === AW'(10 + i) && sa_anterior_data_out === AW'(1 + i) &&
            sa_atualizar_classificacao_out === 1'b0)) begin
        failures++;
        $display("FAIL b2b_slot%0d got we=%b idx=%0d addr=%0d data=%0d upd=%b", i,
                 sa_anterior_wr_en_out, sa_indice_out, sa_anterior_addr_out,
                 sa_anterior_data_out, sa_atualizar_classificacao_out);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_atualizar_classificacao_out === 1'b1 && sa_anterior_wr_en_out === 1'b0)) begin
      failures++;
      $display("FAIL b2b_fim got upd=%b we=%b want 1 0", sa_atualizar_classificacao_out,
               sa_anterior_wr_en_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_snapshot_isolation();
    int exp_k[2] = '{1, 2};
    start_snapshot(4'b0110, 1'b1);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      aa_pronto_in    = 1'b0;
      aa_endereco_in  = '1;
      aa_anterior_data_in = '0;
      aa_aprovado_in  = 4'b1111;
      #1;
      checks++;
      if (!(sa_valido_out === 1'b1 && sa_indice_out === IW'(exp_k[n]) &&
            sa_endereco_out === AW'(10 + exp_k[n]) && sa_anterior_data_out === AW'(1 + exp_k[n]))) begin
        failures++;
        $display("FAIL snap_node%0d got v=%b idx=%0d addr=%0d data=%0d want idx=%0d addr=%0d",
                 n, sa_valido_out, sa_indice_out, sa_endereco_out, sa_anterior_data_out,
                 exp_k[n], 10 + exp_k[n]);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (!(sa_atualizar_classificacao_out === 1'b1 && sa_valido_out === 1'b0)) begin
      failures++;
      $display("FAIL snap_fim got upd=%b v=%b want 1 0", sa_atualizar_classificacao_out, sa_valido_out);
    end
    repeat (2) @(negedge clk);
    aa_endereco_in = END_BASE;
    aa_anterior_data_in = ANT_BASE;
  endtask

  task automatic test_reset_mid_emit();
    start_snapshot(4'b0110, 1'b0);
    @(negedge clk);
    aa_pronto_in = 1'b0;
    #1;
    checks++;
    if (!(sa_valido_out === 1'b1 && sa_indice_out === 2'd1)) begin
      failures++;
      $display("FAIL rst_pre got v=%b idx=%0d want 1 1", sa_valido_out, sa_indice_out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lvv_ready_in = 1'b1;
    #1;
    checks++;
    if ({sa_valido_out, sa_anterior_wr_en_out, sa_atualizar_classificacao_out,
         sa_sem_aprovado_out, sa_ocupado_out, sa_endereco_out, sa_indice_out} !== '0) begin
      failures++;
      $display("FAIL rst_mid got v=%b we=%b upd=%b busy=%b addr=%0d want all 0", sa_valido_out,
               sa_anterior_wr_en_out, sa_atualizar_classificacao_out, sa_ocupado_out, sa_endereco_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({sa_atualizar_classificacao_out, sa_anterior_wr_en_out, sa_valido_out} !== 3'b000) begin
        failures++;
        $display("FAIL rst_quiet%0d got upd=%b we=%b v=%b want 000", c,
                 sa_atualizar_classificacao_out, sa_anterior_wr_en_out, sa_valido_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_nodes();
    test_none_approved();
    test_backpressure();
    test_back_to_back();
    test_snapshot_isolation();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
